// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a tagged response register.
// Optional EQ cross-check enabled by defining ALU_ARB_EQ_CHECK_EN.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [2:0]       req1_ctrl,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_eq,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_eq
`ifdef ALU_ARB_EQ_CHECK_EN
  ,
  output logic             eq_mismatch
`endif
);

  if (NREQ != 2) begin : g_bad_nreq
    $error("alu_arbiter: NREQ must be 2");
  end

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_eq_q, rsp_eq_d;
  logic             ptr_q, ptr_d;

  logic can_issue;
  logic any_valid;
  logic win;
  logic accept;
  logic sum_zero;
  logic is_cmp;

  // Reset cycle never issues, so readys are gated by rst_n too
  assign can_issue = rst_n && (!rsp_valid_q || rsp_ready);
  assign any_valid = req0_valid || req1_valid;
  assign win = (req0_valid && req1_valid) ? ptr_q : req1_valid;
  assign accept = can_issue && any_valid;

  assign req0_ready = accept && !win;
  assign req1_ready = accept && win;

  always_comb begin
    alu_op1  = '0;
    alu_op2  = '0;
    alu_ctrl = 3'b000;
    if (accept) begin
      unique case (1'b1)
        !win: begin
          alu_op1  = req0_op1;
          alu_op2  = req0_op2;
          alu_ctrl = req0_ctrl;
        end
        win: begin
          alu_op1  = req1_op1;
          alu_op2  = req1_op2;
          alu_ctrl = req1_ctrl;
        end
      endcase
    end
  end

  assign sum_zero = (alu_sum == '0);
  assign is_cmp   = (alu_ctrl == 3'b001);

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_eq_d    = rsp_eq_q;
    ptr_d       = ptr_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = win;
      rsp_sum_d   = alu_sum;
      rsp_eq_d    = is_cmp && sum_zero;
      ptr_d       = ~win;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_eq_q    <= 1'b0;
      ptr_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_eq_q    <= rsp_eq_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_eq    = rsp_eq_q;

`ifdef ALU_ARB_EQ_CHECK_EN
  logic mism_q, mism_d;
  logic mism_now;

  assign mism_now = accept && is_cmp && (alu_eq != sum_zero);
  assign mism_d   = mism_q || mism_now;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mism_q <= 1'b0;
    end else begin
      mism_q <= mism_d;
      if (mism_now)
        $error("alu_arbiter: ALU EQ disagrees with SUM==0");
    end
  end

  assign eq_mismatch = mism_q;
`else
  logic unused_alu_eq;
  assign unused_alu_eq = alu_eq;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU (ALUop1/ALUop2/ALUctrl in; SUM/EQ out) between two requesters, e.g. the execute stage and a branch-target/compare helper.
- Arbitration is round-robin with valid/ready handshakes on each request port.
- The block drives the ALU inputs for the granted request and captures SUM/EQ into a one-entry response register.
- The response register is tagged with the requester ID and held under backpressure.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU WIDTH.
- NREQ, 2, number of requesters; fixed at 2 in this revision, and any other value is a synthesis error.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  synchronous active-low reset; sampled on the rising edge of clk
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_op1  input  WIDTH  requester 0 operand 1
- req0_op2  input  WIDTH  requester 0 operand 2
- req0_ctrl  input  3  requester 0 ALU control (000 add, 001 sub/compare)
- req1_valid, req1_ready, req1_op1, req1_op2, req1_ctrl  same as above, for requester 1
- alu_op1  output  WIDTH  to ALU ALUop1
- alu_op2  output  WIDTH  to ALU ALUop2
- alu_ctrl  output  3  to ALU ALUctrl
- alu_sum  input  WIDTH  from ALU SUM
- alu_eq  input  1  from ALU EQ
- rsp_valid  output  1  response register holds a result
- rsp_ready  input  1  consumer accepts the response
- rsp_id  output  1  requester that issued the response
- rsp_sum  output  WIDTH  captured SUM
- rsp_eq  output  1  captured EQ; forced to 0 unless ctrl was 001

Behaviour:
- Reset (rst_n=0 at a clk edge) sets rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_eq=0 and the round-robin pointer to 0 (requester 0 has priority).
- Reset mid-operation discards any held response; no request is accepted in the reset cycle (both readys 0).
- can_issue = !rsp_valid || rsp_ready. When it is 0, both readys are 0 and the ALU inputs are don't-care, but are driven to 0.
- Grant, combinational in the same cycle:
  - Only one valid: that requester wins.
  - Both valid: the requester indicated by the pointer wins.
  - reqN_ready = can_issue && (grant==N).
  - At most one ready is high per cycle; ready never depends on the same requester's data.
- While the grant is valid, alu_op1/alu_op2/alu_ctrl are driven from the winner. When no request is valid, they are driven to 0 and alu_ctrl=000.
- Accept (valid && ready) at edge T:
  - rsp_valid=1, rsp_id=winner, rsp_sum=alu_sum.
  - rsp_eq = (ctrl==001) ? (alu_sum==0) : 0. The captured EQ is recomputed from alu_sum, so the ALU's own EQ hold-over behaviour is ignored; alu_eq is used only under the optional check.
  - Latency: result is visible 1 cycle after acceptance.
- Pointer update occurs only on an accept: pointer = ~winner. With no accept, the pointer holds.
- Response drain: rsp_valid && rsp_ready && no new accept clears rsp_valid. Drain and accept in the same edge overwrite the register with the new result (full throughput, 1 op/cycle).
- Backpressure: while rsp_valid && !rsp_ready, rsp_id/rsp_sum/rsp_eq are stable.
- Requesters must hold valid and data stable until ready. Deasserting valid before ready is legal; the request is simply dropped, with no side effects.
- ctrl values other than 000/001 are passed to the ALU unchanged. The result is captured as the ALU returns it (0), with rsp_eq=0.
- Starvation bound: a continuously valid requester is accepted within 2 issue slots.

Optional Feature:
- Macro ALU_ARB_EQ_CHECK_EN.
- When defined: on every accept with ctrl==001, the block compares alu_eq against (alu_sum==0). A mismatch sets a sticky output eq_mismatch (1 bit, reset 0, cleared only by reset), and a simulation $error fires.
- When not defined: the eq_mismatch port and its logic are absent, and alu_eq is unused.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 with no valids -> rsp_valid=0, both readys 0, alu_ctrl=000, alu_op1=0.
- Single add: req0 op1=5, op2=7, ctrl=000, rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_sum=12, rsp_eq=0.
- Compare equal: req1 op1=0x10, op2=0x10, ctrl=001 -> rsp_sum=0, rsp_eq=1, rsp_id=1; then op2=0x11 -> rsp_sum=0xFFFFFFFF, rsp_eq=0.
- Contention: both valid for 4 cycles, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence is 0,1,0,1 on consecutive cycles.
- Backpressure: rsp_ready=0 after the first result (sum=3) while req1 stays valid -> req1_ready=0 and rsp_sum stays 3 for 5 cycles. Raising rsp_ready -> req1 is accepted that edge and the new result appears next cycle.
- Reset mid-hold: rsp_valid=1 and rsp_ready=0, assert rst_n=0 for one edge -> rsp_valid=0, pointer=0; with both valid afterwards, requester 0 wins first.
